// File: rtl/apb_pkg.sv
// Shared types for the APB requester bridge: FSM states, request/response
// records and default bus widths.
package apb_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int APB_STRB_W  = APB_DATA_W / 8;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

    // Reads never carry byte strobes on the bus.
    function automatic logic [APB_STRB_W-1:0] apb_strb_out(input apb_req_t r);
        return r.write ? r.strb : '0;
    endfunction

endpackage

// File: rtl/apb_access_watchdog.sv
// Counts ACCESS cycles spent waiting on PREADY; flags expiry on the last
// allowed wait cycle. TIMEOUT = 0 disables the watchdog entirely.
module apb_access_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CMAX = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;

    logic [CW-1:0] count;

    // Saturating so the counter can never wrap back into range.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CMAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/apb_req_bridge.sv
// Valid/ready request channel to single APB4 transfers, one outstanding,
// with a watchdog-bounded ACCESS phase and a held response channel.
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   SETUP  | PSEL high, PENABLE low, one cycle
//   ACCESS | PSEL and PENABLE high, waiting on PREADY or watchdog
//   RESP   | rsp_valid high until rsp_ready
module apb_req_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int TIMEOUT    = APB_TIMEOUT
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR
);

    apb_state_t state, state_nxt;
    apb_req_t   req_q;
    apb_rsp_t   rsp_q;
    logic       ready_q;
    logic       accept;
    logic       wd_clear, wd_enable, wd_expired;

    assign accept = (state == IDLE) && ready_q && req_valid;

    always_comb begin
        state_nxt = state;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    wd_clear  = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                wd_enable = !PREADY;
                if (PREADY || wd_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // req_ready is registered so it reads 0 while reset is held.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == IDLE);
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.addr  <= APB_ADDR_W'(req_addr);
            req_q.write <= req_write;
            req_q.wdata <= APB_DATA_W'(req_wdata);
            req_q.strb  <= APB_STRB_W'(req_strb);
        end
    end

    // PREADY takes priority over a same-cycle watchdog expiry.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_q <= '0;
        end else if (state == ACCESS) begin
            if (PREADY) begin
                rsp_q.rdata   <= req_q.write ? '0 : APB_DATA_W'(PRDATA);
                rsp_q.err     <= PSLVERR;
                rsp_q.timeout <= 1'b0;
            end else if (wd_expired) begin
                rsp_q.rdata   <= '0;
                rsp_q.err     <= 1'b1;
                rsp_q.timeout <= 1'b1;
            end
        end
    end

    apb_access_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign req_ready   = ready_q;
    assign rsp_valid   = (state == RESP);
    assign rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    assign PSEL    = (state == SETUP) || (state == ACCESS);
    assign PENABLE = (state == ACCESS);
    assign PADDR   = ADDR_WIDTH'(req_q.addr);
    assign PWRITE  = req_q.write;
    assign PWDATA  = DATA_WIDTH'(req_q.wdata);
    assign PSTRB   = (DATA_WIDTH/8)'(apb_strb_out(req_q));

endmodule
